im_loader: RTL and testbench
============================

IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 Parameter DEPTH, default 64, instruction-memory capacity in 32-bit words (power of two, 4..1024).
REQ-002 Parameter BASE_ADDR, default 64'h0, byte address of the first word written.
REQ-003 Clock  input  1  single system clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  one-cycle pulse that begins a load session; ignored outside IDLE.
REQ-006 ByteIn  input  8  next stream byte.
REQ-007 ByteValid  input  1  ByteIn is valid.
REQ-008 ByteLast  input  1  qualifies ByteIn as the final instruction byte.
REQ-009 ByteReady  output  1  loader accepts ByteIn this cycle.
REQ-010 WrEn  output  1  instruction-memory write strobe, one cycle per word.
REQ-011 WrAddr  output  64  byte address of the word being written, in PC address space.
REQ-012 WrData  output  32  assembled instruction word.
REQ-013 WordCount  output  32  number of words written this session.
REQ-014 Done  output  1  session complete; held until next Start or Reset.
REQ-015 ChkErr  output  1  checksum mismatch flag; held with Done.

Function
REQ-016 A byte is transferred only on a cycle with ByteValid=1 and ByteReady=1.
REQ-017 FSM states: IDLE, LOAD, WRITE, CHECK (macro only), DONE.
REQ-018 IDLE: ByteReady=0; Start=1 -> LOAD; clears WordCount, Done, ChkErr, byte index; WrAddr=BASE_ADDR.
REQ-019 LOAD: ByteReady=1; accepted bytes fill WrData little-endian (first byte -> [7:0], fourth -> [31:24]).
REQ-020 LOAD -> WRITE on acceptance of the fourth byte, or of any byte with ByteLast=1.
REQ-021 A partial word ended by ByteLast is zero-padded in the unfilled upper bytes.
REQ-022 WRITE: ByteReady=0, WrEn=1 for exactly one cycle with current WrAddr/WrData; next cycle WordCount+=1, WrAddr+=4, byte index cleared.
REQ-023 After WRITE: last byte seen -> CHECK (macro) or DONE; WordCount reaching DEPTH -> DONE (remaining stream bytes not accepted); otherwise -> LOAD.
REQ-024 Write latency: WrEn asserts the cycle after the word-completing byte is accepted.
REQ-025 Addresses never wrap: at most DEPTH writes per session, last WrAddr = BASE_ADDR+4*(DEPTH-1).
REQ-026 DONE: ByteReady=0, WrEn=0, Done=1; Start=1 -> LOAD, restarting the session as in REQ-018.
REQ-027 Start during LOAD, WRITE or CHECK is ignored.
REQ-028 ByteLast on a byte arriving while ByteReady=0 has no effect.

Reset
REQ-029 Reset=1 at a rising edge forces IDLE, ByteReady=0, WrEn=0, WrAddr=BASE_ADDR, WrData=0, WordCount=0, Done=0, ChkErr=0.
REQ-030 Reset mid-session aborts the session; no WrEn issued in the reset cycle or after it until a new Start.
REQ-031 Reset has priority over Start and every byte transfer in the same cycle.

Configuration
REQ-032 Macro IM_LOADER_CHECKSUM_EN.
REQ-033 Defined: running 8-bit XOR of all accepted instruction bytes; after the final WRITE enter CHECK, ByteReady=1, accept one checksum byte, set ChkErr=1 if it differs from the XOR, then DONE.
REQ-034 Undefined: CHECK state absent, no checksum byte consumed, ChkErr tied to 0.

Verification
REQ-035 Reset, Start, bytes 20 00 80 D2 -> one WrEn, WrAddr=0, WrData=D2800020, WordCount=1.
REQ-036 Eight bytes, ByteLast on eighth -> WrEn at addresses 0 and 4, Done=1, WordCount=2.
REQ-037 Five bytes 01..05, ByteLast on fifth -> second word WrData=00000005, WordCount=2.
REQ-038 DEPTH=4, 20-byte stream -> exactly 4 writes, last WrAddr=12, Done=1, ByteReady=0 for remaining bytes.
REQ-039 Reset asserted after second byte of a word -> no WrEn, all outputs at reset values; new Start reloads from BASE_ADDR.
REQ-040 With IM_LOADER_CHECKSUM_EN, bytes 01 02 03 04 last, then checksum 04 -> ChkErr=0; checksum 05 -> ChkErr=1, Done=1.

Source files
------------

// File: rtl/im_loader.sv
// ----------------------------------------------------------------------------
// im_loader
// Turns a byte stream into 32-bit instruction words and writes them into
// instruction memory. Words are packed little-endian, and consecutive words go
// to consecutive byte addresses starting at BASE_ADDR. A session ends on the
// byte flagged ByteLast, or when DEPTH words have been written.
//
// Optional feature (macro IM_LOADER_CHECKSUM_EN):
//   After the final word, one extra checksum byte is accepted. It is compared
//   against the running XOR of every instruction byte, and ChkErr is set on a
//   mismatch. When the macro is not defined, no checksum byte is consumed and
//   ChkErr is tied to 0.
//
// Ports:
//   Clock      in   system clock, rising edge
//   Reset      in   synchronous, active-high
//   Start      in   begins a session (ignored unless idle/done)
//   ByteIn     in   [7:0] stream byte
//   ByteValid  in   ByteIn is valid
//   ByteLast   in   ByteIn is the final instruction byte
//   ByteReady  out  loader accepts ByteIn this cycle
//   WrEn       out  one-cycle write strobe per word
//   WrAddr     out  [63:0] byte address of the word being written
//   WrData     out  [31:0] assembled word
//   WordCount  out  [31:0] words written this session
//   Done       out  session complete
//   ChkErr     out  checksum mismatch (held with Done)
// ----------------------------------------------------------------------------
module im_loader #(
    parameter int unsigned DEPTH     = 64,
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [7:0]  ByteIn,
    input  logic        ByteValid,
    input  logic        ByteLast,
    output logic        ByteReady,
    output logic        WrEn,
    output logic [63:0] WrAddr,
    output logic [31:0] WrData,
    output logic [31:0] WordCount,
    output logic        Done,
    output logic        ChkErr
);

`ifdef IM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_CHECK, S_DONE} state_e;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_e;
`endif

    state_e      state_q, state_d;
    logic [63:0] addr_q,  addr_d;
    logic [31:0] data_q,  data_d;
    logic [31:0] count_q, count_d;
    logic [1:0]  idx_q,   idx_d;
    logic        last_q,  last_d;
`ifdef IM_LOADER_CHECKSUM_EN
    logic [7:0]  xor_q,   xor_d;
    logic        chk_q,   chk_d;
`endif

    logic accept;
    assign accept = ByteValid & ByteReady;

    // State and datapath registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            addr_q  <= BASE_ADDR;
            data_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
            xor_q   <= '0;
            chk_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
`ifdef IM_LOADER_CHECKSUM_EN
            xor_q   <= xor_d;
            chk_q   <= chk_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (Start) state_d = S_LOAD;
            S_LOAD:  if (accept && (idx_q == 2'd3 || ByteLast)) state_d = S_WRITE;
            S_WRITE: begin
                // The end-of-stream marker takes precedence over the depth limit,
                // so a stream that exactly fills memory still gets its checksum.
                if (last_q) begin
`ifdef IM_LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else if (count_q + 32'd1 == DEPTH) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_LOAD;
                end
            end
`ifdef IM_LOADER_CHECKSUM_EN
            S_CHECK: if (accept) state_d = S_DONE;
`endif
            S_DONE:  if (Start) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        count_d = count_q;
        idx_d   = idx_q;
        last_d  = last_q;
`ifdef IM_LOADER_CHECKSUM_EN
        xor_d   = xor_q;
        chk_d   = chk_q;
`endif
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    addr_d  = BASE_ADDR;
                    count_d = '0;
                    idx_d   = '0;
                    last_d  = 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
                    xor_d   = '0;
                    chk_d   = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                if (accept) begin
                    // The first byte of a word clears the upper lanes. This
                    // zero-pads a short final word.
                    if (idx_q == 2'd0) begin
                        data_d = {24'h0, ByteIn};
                    end else begin
                        data_d[{idx_q, 3'b000} +: 8] = ByteIn;
                    end
                    idx_d  = idx_q + 2'd1;
                    last_d = ByteLast;
`ifdef IM_LOADER_CHECKSUM_EN
                    xor_d  = xor_q ^ ByteIn;
`endif
                end
            end
            S_WRITE: begin
                count_d = count_q + 32'd1;
                addr_d  = addr_q + 64'd4;
                idx_d   = '0;
            end
`ifdef IM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) chk_d = (ByteIn != xor_q);
            end
`endif
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        ByteReady = 1'b0;
        WrEn      = 1'b0;
        Done      = 1'b0;
        unique case (state_q)
            S_LOAD:  ByteReady = 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
            S_CHECK: ByteReady = 1'b1;
`endif
            S_WRITE: WrEn      = 1'b1;
            S_DONE:  Done      = 1'b1;
            default: ;
        endcase
    end

    assign WrAddr    = addr_q;
    assign WrData    = data_q;
    assign WordCount = count_q;
`ifdef IM_LOADER_CHECKSUM_EN
    assign ChkErr    = chk_q;
`else
    assign ChkErr    = 1'b0;
`endif

endmodule

// File: tb/tb_im_loader.sv
// ----------------------------------------------------------------------------
// tb_im_loader
// Directed bench with a write scoreboard. Two loaders share the clock and
// reset: dut_a uses DEPTH=64 and dut_b uses DEPTH=4. Each accepted stream
// byte is also fed to a small word-packing model, which pushes the expected
// write {addr, data} to that DUT's queue. Monitors pop and compare entries as
// WrEn appears.
// ----------------------------------------------------------------------------
module tb_im_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_a, valid_a, last_a, start_b, valid_b, last_b;
    logic [7:0]  byte_a, byte_b;
    logic        ready_a, wren_a, done_a, chk_a;
    logic        ready_b, wren_b, done_b, chk_b;
    logic [63:0] addr_a, addr_b;
    logic [31:0] data_a, data_b, cnt_a, cnt_b;

    im_loader #(.DEPTH(64), .BASE_ADDR(64'h0)) dut_a (
        .Clock(clk), .Reset(rst), .Start(start_a), .ByteIn(byte_a),
        .ByteValid(valid_a), .ByteLast(last_a), .ByteReady(ready_a),
        .WrEn(wren_a), .WrAddr(addr_a), .WrData(data_a), .WordCount(cnt_a),
        .Done(done_a), .ChkErr(chk_a)
    );

    im_loader #(.DEPTH(4), .BASE_ADDR(64'h0)) dut_b (
        .Clock(clk), .Reset(rst), .Start(start_b), .ByteIn(byte_b),
        .ByteValid(valid_b), .ByteLast(last_b), .ByteReady(ready_b),
        .WrEn(wren_b), .WrAddr(addr_b), .WrData(data_b), .WordCount(cnt_b),
        .Done(done_b), .ChkErr(chk_b)
    );

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_a[$];
    wr_t exp_b[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  wr_cnt_a = 0;
    int  wr_cnt_b = 0;

    // Model state, indexed by DUT select (0 = a, 1 = b)
    int          m_idx[2];
    int          m_n[2];
    logic [31:0] m_word[2];
    logic [7:0]  m_xor[2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wren_a === 1'b1) begin
            wr_t e;
            wr_cnt_a++;
            if (exp_a.size() == 0) begin
                check("wr_a_unexpected", 64'(exp_a.size()), 64'd1);
            end else begin
                e = exp_a.pop_front();
                check("wr_a_addr", addr_a, e.addr);
                check("wr_a_data", 64'(data_a), 64'(e.data));
            end
        end
    end

    always @(negedge clk) begin
        if (wren_b === 1'b1) begin
            wr_t e;
            wr_cnt_b++;
            if (exp_b.size() == 0) begin
                check("wr_b_unexpected", 64'(exp_b.size()), 64'd1);
            end else begin
                e = exp_b.pop_front();
                check("wr_b_addr", addr_b, e.addr);
                check("wr_b_data", 64'(data_b), 64'(e.data));
            end
        end
    end

    task automatic model_byte(input bit sel, input logic [7:0] b, input bit last);
        logic [31:0] w;
        wr_t         e;
        int          depth;
        depth = sel ? 4 : 64;
        w = (m_idx[sel] == 0) ? 32'h0 : m_word[sel];
        w[8*m_idx[sel] +: 8] = b;
        m_word[sel] = w;
        m_xor[sel]  = m_xor[sel] ^ b;
        if (m_idx[sel] == 3 || last) begin
            if (m_n[sel] < depth) begin
                e.addr = 64'(4 * m_n[sel]);
                e.data = w;
                if (sel) exp_b.push_back(e); else exp_a.push_back(e);
            end
            m_n[sel]++;
            m_idx[sel] = 0;
        end else begin
            m_idx[sel]++;
        end
    endtask

    // Present one byte and hold it until the handshake completes, or until
    // the cycle budget runs out.
    task automatic feed(input bit sel, input logic [7:0] b, input bit last, output bit ok);
        if (sel) begin byte_b = b; valid_b = 1'b1; last_b = last; end
        else     begin byte_a = b; valid_a = 1'b1; last_a = last; end
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if ((sel ? ready_b : ready_a) === 1'b1) ok = 1'b1;
        end
        @(posedge clk); #1;
        if (sel) begin valid_b = 1'b0; last_b = 1'b0; end
        else     begin valid_a = 1'b0; last_a = 1'b0; end
    endtask

    task automatic send(input bit sel, input logic [7:0] b, input bit last);
        bit ok;
        model_byte(sel, b, last);
        feed(sel, b, last, ok);
        check(sel ? "handshake_b" : "handshake_a", 64'(ok), 64'd1);
    endtask

    // Checksum byte that follows a ByteLast-terminated stream, when enabled
    task automatic send_checksum(input bit sel, input logic [7:0] b);
`ifdef IM_LOADER_CHECKSUM_EN
        bit ok;
        feed(sel, b, 1'b0, ok);
        check("handshake_chk", 64'(ok), 64'd1);
`endif
    endtask

    task automatic do_start(input bit sel);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        m_idx[sel] = 0; m_n[sel] = 0; m_xor[sel] = 8'h0; m_word[sel] = 32'h0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_wr;
        rst = 1'b1;
        start_a = 0; valid_a = 0; last_a = 0; byte_a = 0;
        start_b = 0; valid_b = 0; last_b = 0; byte_b = 0;
        for (int i = 0; i < 2; i++) begin
            m_idx[i] = 0; m_n[i] = 0; m_word[i] = 0; m_xor[i] = 0;
        end

        // Reset state
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 64'(ready_a), 64'd0);
        check("rst_wren",  64'(wren_a),  64'd0);
        check("rst_addr",  addr_a,       64'h0);
        check("rst_data",  64'(data_a),  64'h0);
        check("rst_count", 64'(cnt_a),   64'h0);
        check("rst_done",  64'(done_a),  64'd0);
        check("rst_chk",   64'(chk_a),   64'd0);
        check("rst_ready_b", 64'(ready_b), 64'd0);
        @(posedge clk); #1;

        // One full word; a Start mid-word must be ignored
        do_start(1'b0);
        send(1'b0, 8'h20, 1'b0);
        send(1'b0, 8'h00, 1'b0);
        start_a = 1'b1; @(posedge clk); #1; start_a = 1'b0;
        send(1'b0, 8'h80, 1'b0);
        send(1'b0, 8'hD2, 1'b0);
        repeat (3) @(negedge clk);
        check("w1_count",  64'(cnt_a),    64'd1);
        check("w1_wrcnt",  64'(wr_cnt_a), 64'd1);
        check("w1_data",   64'(data_a),   64'hD280_0020);
        check("w1_addr",   addr_a,        64'd4);
        check("w1_ready",  64'(ready_a),  64'd1);
        @(posedge clk); #1;

        // Eight bytes, last on the eighth
        pulse_reset();
        base_wr = wr_cnt_a;
        do_start(1'b0);
        for (int i = 0; i < 8; i++) send(1'b0, 8'(8'h11 * (i + 1)), i == 7);
        send_checksum(1'b0, m_xor[0]);
        repeat (3) @(negedge clk);
        check("w2_wrcnt", 64'(wr_cnt_a - base_wr), 64'd2);
        check("w2_count", 64'(cnt_a),   64'd2);
        check("w2_done",  64'(done_a),  64'd1);
        check("w2_ready", 64'(ready_a), 64'd0);
        check("w2_chk",   64'(chk_a),   64'd0);
        @(posedge clk); #1;

        // Five bytes: partial second word zero-padded; restart from DONE
        base_wr = wr_cnt_a;
        do_start(1'b0);
        for (int i = 1; i <= 5; i++) send(1'b0, 8'(i), i == 5);
        send_checksum(1'b0, m_xor[0]);
        repeat (3) @(negedge clk);
        check("w3_wrcnt", 64'(wr_cnt_a - base_wr), 64'd2);
        check("w3_data",  64'(data_a), 64'h0000_0005);
        check("w3_count", 64'(cnt_a),  64'd2);
        check("w3_done",  64'(done_a), 64'd1);
        @(posedge clk); #1;

        // Bytes offered in DONE (with ByteLast) are ignored
        base_wr = wr_cnt_a;
        byte_a = 8'h77; valid_a = 1'b1; last_a = 1'b1;
        repeat (3) @(posedge clk); #1;
        valid_a = 1'b0; last_a = 1'b0;
        @(negedge clk);
        check("idle_last_wrcnt", 64'(wr_cnt_a - base_wr), 64'd0);
        check("idle_last_count", 64'(cnt_a),  64'd2);
        check("idle_last_done",  64'(done_a), 64'd1);
        @(posedge clk); #1;

        // DEPTH=4: a 20-byte stream stops after four writes
        do_start(1'b1);
        for (int i = 0; i < 16; i++) send(1'b1, 8'(i + 8'h40), 1'b0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        byte_b = 8'hEE; valid_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("depth_ready", 64'(ready_b), 64'd0);
        end
        @(posedge clk); #1;
        valid_b = 1'b0;
        @(negedge clk);
        check("depth_wrcnt", 64'(wr_cnt_b), 64'd4);
        check("depth_count", 64'(cnt_b),    64'd4);
        check("depth_done",  64'(done_b),   64'd1);
        check("depth_addr",  addr_b,        64'd16);
        @(posedge clk); #1;

        // Reset mid-word, with a byte offered in the reset cycle
        do_start(1'b0);
        send(1'b0, 8'hA1, 1'b0);
        send(1'b0, 8'hA2, 1'b0);
        base_wr = wr_cnt_a;
        byte_a = 8'hA3; valid_a = 1'b1; last_a = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; valid_a = 1'b0; last_a = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_wrcnt", 64'(wr_cnt_a - base_wr), 64'd0);
        check("abort_ready", 64'(ready_a), 64'd0);
        check("abort_addr",  addr_a,       64'h0);
        check("abort_data",  64'(data_a),  64'h0);
        check("abort_count", 64'(cnt_a),   64'h0);
        check("abort_done",  64'(done_a),  64'd0);
        @(posedge clk); #1;
        do_start(1'b0);
        send(1'b0, 8'h13, 1'b0);
        send(1'b0, 8'h05, 1'b0);
        send(1'b0, 8'h00, 1'b0);
        send(1'b0, 8'h93, 1'b0);
        repeat (3) @(negedge clk);
        check("reload_count", 64'(cnt_a), 64'd1);
        @(posedge clk); #1;

`ifdef IM_LOADER_CHECKSUM_EN
        // Checksum good / bad
        for (int pass = 0; pass < 2; pass++) begin
            pulse_reset();
            do_start(1'b0);
            for (int i = 1; i <= 4; i++) send(1'b0, 8'(i), i == 4);
            send_checksum(1'b0, (pass == 0) ? 8'h04 : 8'h05);
            repeat (3) @(negedge clk);
            check("chk_err",  64'(chk_a),  (pass == 0) ? 64'd0 : 64'd1);
            check("chk_done", 64'(done_a), 64'd1);
            @(posedge clk); #1;
        end
`endif

        repeat (3) @(negedge clk);
        check("sb_a_empty", 64'(exp_a.size()), 64'd0);
        check("sb_b_empty", 64'(exp_b.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
